// File: rtl/branch_pkg.sv
// Shared definitions for the branch resolver: condition codes, FSM state
// encoding and flush-counter width.
package branch_pkg;

  localparam logic [3:0] COND_AL = 4'h0;
  localparam logic [3:0] COND_EQ = 4'h1;
  localparam logic [3:0] COND_NE = 4'h2;
  localparam logic [3:0] COND_CS = 4'h3;
  localparam logic [3:0] COND_CC = 4'h4;
  localparam logic [3:0] COND_MI = 4'h5;
  localparam logic [3:0] COND_PL = 4'h6;
  localparam logic [3:0] COND_VS = 4'h7;
  localparam logic [3:0] COND_VC = 4'h8;
  localparam logic [3:0] COND_HI = 4'h9;
  localparam logic [3:0] COND_LS = 4'hA;
  localparam logic [3:0] COND_GE = 4'hB;
  localparam logic [3:0] COND_LT = 4'hC;
  localparam logic [3:0] COND_GT = 4'hD;
  localparam logic [3:0] COND_LE = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  localparam int CNT_WIDTH = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch condition decoder; flags are packed {Z,N,V,C}.
module branch_cond_eval
  import branch_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       taken
);

  logic z, n, v, c;
  assign z = flags[3];
  assign n = flags[2];
  assign v = flags[1];
  assign c = flags[0];

  always_comb begin
    taken = 1'b0;
    case (cond)
      COND_AL: taken = 1'b1;
      COND_EQ: taken = z;
      COND_NE: taken = !z;
      COND_CS: taken = c;
      COND_CC: taken = !c;
      COND_MI: taken = n;
      COND_PL: taken = !n;
      COND_VS: taken = v;
      COND_VC: taken = !v;
      COND_HI: taken = c && !z;
      COND_LS: taken = !c || z;
      COND_GE: taken = (n == v);
      COND_LT: taken = (n != v);
      COND_GT: taken = !z && (n == v);
      COND_LE: taken = z || (n != v);
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve.sv
// Branch resolver: flag register, target adder and IDLE/FLUSH sequencer.
// Optional BRANCH_STATS_EN adds saturating taken/not-taken counters.
//
// state    | meaning
// ST_IDLE  | accepting branches from decode
// ST_FLUSH | flush asserted, counting down FLUSH_CYCLES unstalled cycles
module branch_resolve
  import branch_pkg::*;
#(
  parameter int ADDR_WIDTH   = 16,
  parameter int OFFSET_WIDTH = 8,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    branch_d,
  input  logic [3:0]              branch_condition_d,
  input  logic [ADDR_WIDTH-1:0]   pc_d,
  input  logic [OFFSET_WIDTH-1:0] offset_d,
  input  logic                    flag_we,
  input  logic                    Z,
  input  logic                    N,
  input  logic                    V,
  input  logic                    C,
  input  logic                    stall,
  output logic                    PC_source,
  output logic [ADDR_WIDTH-1:0]   branch_target,
  output logic                    flush,
  output logic                    busy,
`ifdef BRANCH_STATS_EN
  output logic [15:0]             taken_count,
  output logic [15:0]             not_taken_count,
`endif
  output logic [3:0]              flags_q
);

  state_t                 state, state_next;
  logic [CNT_WIDTH-1:0]   cnt, cnt_next;
  logic [3:0]             flags_in, flags_eval;
  logic                   taken, accept, accept_taken;
  logic [ADDR_WIDTH-1:0]  offset_ext, target_sum;

  assign flags_in   = {Z, N, V, C};
  // Forward same-cycle flag writes so a branch right behind a compare sees them.
  assign flags_eval = flag_we ? flags_in : flags_q;

  branch_cond_eval u_cond_eval (
    .cond  (branch_condition_d),
    .flags (flags_eval),
    .taken (taken)
  );

  assign offset_ext   = {{(ADDR_WIDTH-OFFSET_WIDTH){offset_d[OFFSET_WIDTH-1]}}, offset_d};
  assign target_sum   = pc_d + offset_ext;
  assign accept       = branch_d && !stall && (state == ST_IDLE);
  assign accept_taken = accept && taken;

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      ST_IDLE: begin
        if (accept_taken) begin
          state_next = ST_FLUSH;
          cnt_next   = CNT_WIDTH'(FLUSH_CYCLES);
        end
      end
      ST_FLUSH: begin
        if (!stall) begin
          if (cnt <= CNT_WIDTH'(1)) begin
            state_next = ST_IDLE;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt - CNT_WIDTH'(1);
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      flags_q       <= '0;
      branch_target <= '0;
      PC_source     <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      PC_source <= accept_taken;
      if (flag_we)      flags_q       <= flags_in;
      if (accept_taken) branch_target <= target_sum;
    end
  end

  assign flush = (state == ST_FLUSH);
  assign busy  = (state == ST_FLUSH);

`ifdef BRANCH_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      taken_count     <= '0;
      not_taken_count <= '0;
    end else if (accept) begin
      if (taken && taken_count != 16'hFFFF)
        taken_count <= taken_count + 16'd1;
      if (!taken && not_taken_count != 16'hFFFF)
        not_taken_count <= not_taken_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Self-checking bench for branch_resolve; scoreboard of expected targets
// is popped whenever the DUT pulses PC_source.
module tb_branch_resolve;

  localparam int FC = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        branch_d;
  logic [3:0]  branch_condition_d;
  logic [15:0] pc_d;
  logic [7:0]  offset_d;
  logic        flag_we;
  logic        Z, N, V, C;
  logic        stall;
  logic        PC_source;
  logic [15:0] branch_target;
  logic        flush;
  logic        busy;
  logic [3:0]  flags_q;
`ifdef BRANCH_STATS_EN
  logic [15:0] taken_count;
  logic [15:0] not_taken_count;
`endif

  branch_resolve #(.ADDR_WIDTH(16), .OFFSET_WIDTH(8), .FLUSH_CYCLES(FC)) dut (
    .clk                (clk),
    .reset              (reset),
    .branch_d           (branch_d),
    .branch_condition_d (branch_condition_d),
    .pc_d               (pc_d),
    .offset_d           (offset_d),
    .flag_we            (flag_we),
    .Z                  (Z),
    .N                  (N),
    .V                  (V),
    .C                  (C),
    .stall              (stall),
    .PC_source          (PC_source),
    .branch_target      (branch_target),
    .flush              (flush),
    .busy               (busy),
`ifdef BRANCH_STATS_EN
    .taken_count        (taken_count),
    .not_taken_count    (not_taken_count),
`endif
    .flags_q            (flags_q)
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  logic [15:0] exp_q[$];
  logic [3:0]  tb_flags = 4'h0;
  int          n_taken = 0;
  int          n_not = 0;

  function automatic logic cond_model(input logic [3:0] cd, input logic [3:0] f);
    logic z, n, v, c;
    z = f[3]; n = f[2]; v = f[1]; c = f[0];
    case (cd)
      4'h0: return 1'b1;
      4'h1: return z;
      4'h2: return !z;
      4'h3: return c;
      4'h4: return !c;
      4'h5: return n;
      4'h6: return !n;
      4'h7: return v;
      4'h8: return !v;
      4'h9: return c & !z;
      4'hA: return !c | z;
      4'hB: return n == v;
      4'hC: return n != v;
      4'hD: return !z & (n == v);
      4'hE: return z | (n != v);
      default: return 1'b0;
    endcase
  endfunction

  // Every PC_source pulse must match a queued expectation.
  always @(negedge clk) begin
    if (PC_source === 1'b1) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL pc_source_pulse: got PC_source=1 with no branch pending, expected 0");
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if (branch_target !== e) begin
          fails++;
          $display("FAIL sb_target: got %h expected %h", branch_target, e);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    tb_flags = 4'h0;
    n_taken = 0;
    n_not = 0;
  endtask

  task automatic latch_flags(input logic [3:0] fl);
    flag_we = 1'b1;
    {Z, N, V, C} = fl;
    cyc();
    flag_we = 1'b0;
    tb_flags = fl;
    tests++;
    if (flags_q !== fl) begin
      fails++;
      $display("FAIL flags_latch: got %b expected %b", flags_q, fl);
    end
  endtask

  // Presents one branch assumed to be accepted; returns just after the accepting edge.
  task automatic do_branch(input logic [3:0] cd, input logic [15:0] pc, input logic [7:0] off,
                           input logic we, input logic [3:0] fl, output logic tk);
    logic [3:0] eff;
    eff = we ? fl : tb_flags;
    tk = cond_model(cd, eff);
    branch_d = 1'b1;
    branch_condition_d = cd;
    pc_d = pc;
    offset_d = off;
    flag_we = we;
    {Z, N, V, C} = fl;
    if (tk) begin
      exp_q.push_back(pc + {{8{off[7]}}, off});
      n_taken++;
    end else begin
      n_not++;
    end
    if (we) tb_flags = fl;
    cyc();
    branch_d = 1'b0;
    flag_we = 1'b0;
  endtask

  task automatic measure_flush(output int n);
    n = 0;
    while (flush === 1'b1 && n < 60) begin
      n++;
      cyc();
    end
  endtask

  task automatic wait_idle(input string nm);
    int k;
    k = 0;
    while (busy !== 1'b0 && k < 60) begin
      cyc();
      k++;
    end
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL %s_idle_timeout: got busy=%b expected 0", nm, busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    flag_we = 1'b1;
    {Z, N, V, C} = 4'b1111;
    branch_d = 1'b1;
    branch_condition_d = 4'h0;
    pc_d = 16'h1234;
    offset_d = 8'h10;
    cyc();
    tests += 5;
    if (flags_q !== 4'h0)        begin fails++; $display("FAIL rst_flags: got %b expected 0000", flags_q); end
    if (PC_source !== 1'b0)      begin fails++; $display("FAIL rst_pc_source: got %b expected 0", PC_source); end
    if (flush !== 1'b0)          begin fails++; $display("FAIL rst_flush: got %b expected 0", flush); end
    if (busy !== 1'b0)           begin fails++; $display("FAIL rst_busy: got %b expected 0", busy); end
    if (branch_target !== 16'h0) begin fails++; $display("FAIL rst_target: got %h expected 0000", branch_target); end
    reset = 1'b0;
    flag_we = 1'b0;
    branch_d = 1'b0;
    {Z, N, V, C} = 4'b0000;
    tb_flags = 4'h0;
    cyc();
  endtask

  task automatic test_taken_basic();
    logic tk;
    int n;
    latch_flags(4'b0001);
    do_branch(4'h3, 16'h0010, 8'h04, 1'b0, 4'b0000, tk);
    tests += 3;
    if (PC_source !== 1'b1)          begin fails++; $display("FAIL basic_pc_source: got %b expected 1", PC_source); end
    if (branch_target !== 16'h0014)  begin fails++; $display("FAIL basic_target: got %h expected 0014", branch_target); end
    if (busy !== 1'b1)               begin fails++; $display("FAIL basic_busy: got %b expected 1", busy); end
    measure_flush(n);
    tests++;
    if (n != FC) begin fails++; $display("FAIL basic_flush_len: got %0d expected %0d", n, FC); end
  endtask

  task automatic test_forwarding();
    logic tk;
    latch_flags(4'b1000);
    do_branch(4'h1, 16'h0100, 8'h08, 1'b1, 4'b0000, tk);
    tests += 4;
    if (PC_source !== 1'b0) begin fails++; $display("FAIL fwd_nt_pc_source: got %b expected 0", PC_source); end
    if (flush !== 1'b0)     begin fails++; $display("FAIL fwd_nt_flush: got %b expected 0", flush); end
    if (busy !== 1'b0)      begin fails++; $display("FAIL fwd_nt_busy: got %b expected 0", busy); end
    if (flags_q !== 4'h0)   begin fails++; $display("FAIL fwd_nt_flags: got %b expected 0000", flags_q); end
    do_branch(4'h1, 16'h0100, 8'h08, 1'b1, 4'b1000, tk);
    tests++;
    if (PC_source !== 1'b1) begin fails++; $display("FAIL fwd_t_pc_source: got %b expected 1", PC_source); end
    wait_idle("fwd");
  endtask

  task automatic test_wrap();
    logic tk;
    do_branch(4'h0, 16'h0002, 8'hFC, 1'b0, 4'b0000, tk);
    tests++;
    if (branch_target !== 16'hFFFE) begin fails++; $display("FAIL wrap_target: got %h expected fffe", branch_target); end
    wait_idle("wrap");
    do_branch(4'hF, 16'h1234, 8'h01, 1'b0, 4'b0000, tk);
    tests += 3;
    if (PC_source !== 1'b0)         begin fails++; $display("FAIL never_pc_source: got %b expected 0", PC_source); end
    if (flush !== 1'b0)             begin fails++; $display("FAIL never_flush: got %b expected 0", flush); end
    if (branch_target !== 16'hFFFE) begin fails++; $display("FAIL never_target_hold: got %h expected fffe", branch_target); end
  endtask

  task automatic test_conds();
    logic tk;
    logic [3:0] fl;
    for (int i = 0; i < 32; i++) begin
      fl = 4'($urandom_range(0, 15));
      if (i >= 16) begin
        latch_flags(fl);
        do_branch(4'(i), 16'($urandom), 8'($urandom), 1'b0, ~fl, tk);
      end else begin
        do_branch(4'(i), 16'($urandom), 8'($urandom), 1'b1, fl, tk);
      end
      tests += 2;
      if (PC_source !== tk) begin fails++; $display("FAIL cond_%0d_pc_source: got %b expected %b flags %b", i % 16, PC_source, tk, fl); end
      if (flush !== tk)     begin fails++; $display("FAIL cond_%0d_flush: got %b expected %b", i % 16, flush, tk); end
      wait_idle("cond");
    end
  endtask

  task automatic test_back_to_back();
    logic tk;
    int k;
    do_branch(4'h0, 16'h1000, 8'h10, 1'b0, 4'b0000, tk);
    branch_d = 1'b1;
    branch_condition_d = 4'h0;
    pc_d = 16'h2000;
    offset_d = 8'h00;
    k = 0;
    while (busy === 1'b1 && k < 60) begin
      cyc();
      k++;
    end
    branch_d = 1'b0;
    tests += 2;
    if (k != FC)                    begin fails++; $display("FAIL b2b_flush_len: got %0d expected %0d", k, FC); end
    if (branch_target !== 16'h1010) begin fails++; $display("FAIL b2b_target_hold: got %h expected 1010", branch_target); end
    do_branch(4'h0, 16'h3000, 8'h20, 1'b0, 4'b0000, tk);
    tests += 2;
    if (PC_source !== 1'b1)         begin fails++; $display("FAIL b2b_reaccept: got %b expected 1", PC_source); end
    if (branch_target !== 16'h3020) begin fails++; $display("FAIL b2b_target2: got %h expected 3020", branch_target); end
    wait_idle("b2b");
  endtask

  task automatic test_stall();
    logic tk;
    int n;
    do_branch(4'h0, 16'h0400, 8'h80, 1'b0, 4'b0000, tk);
    stall = 1'b1;
    n = 0;
    repeat (3) begin
      if (flush === 1'b1) n++;
      cyc();
    end
    stall = 1'b0;
    while (flush === 1'b1 && n < 60) begin
      n++;
      cyc();
    end
    tests++;
    if (n != FC + 3) begin fails++; $display("FAIL stall_flush_len: got %0d expected %0d", n, FC + 3); end
  endtask

  task automatic test_reset_mid_flush();
    logic tk;
    do_branch(4'h0, 16'h0800, 8'h01, 1'b0, 4'b0000, tk);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    tb_flags = 4'h0;
    tests += 3;
    if (flush !== 1'b0)     begin fails++; $display("FAIL rstmid_flush: got %b expected 0", flush); end
    if (busy !== 1'b0)      begin fails++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
    if (PC_source !== 1'b0) begin fails++; $display("FAIL rstmid_pc_source: got %b expected 0", PC_source); end
    cyc();
    tests++;
    if (flush !== 1'b0) begin fails++; $display("FAIL rstmid_flush_lost: got %b expected 0", flush); end
  endtask

`ifdef BRANCH_STATS_EN
  task automatic test_stats();
    logic tk;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      do_branch((i % 2 == 0) ? 4'h0 : 4'hF, 16'(i * 16), 8'h02, 1'b0, 4'b0000, tk);
      wait_idle("stats");
    end
    tests += 2;
    if (taken_count !== 16'd3)     begin fails++; $display("FAIL stats_taken: got %0d expected 3", taken_count); end
    if (not_taken_count !== 16'd2) begin fails++; $display("FAIL stats_not_taken: got %0d expected 2", not_taken_count); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    branch_d = 1'b0;
    branch_condition_d = 4'h0;
    pc_d = 16'h0;
    offset_d = 8'h0;
    flag_we = 1'b0;
    {Z, N, V, C} = 4'b0000;
    stall = 1'b0;
    test_reset();
    test_taken_basic();
    test_forwarding();
    test_wrap();
    test_conds();
    test_back_to_back();
    test_stall();
    test_reset_mid_flush();
`ifdef BRANCH_STATS_EN
    test_stats();
`endif
    cyc();
    tests++;
    if (exp_q.size() != 0) begin fails++; $display("FAIL sb_drain: got %0d pending expected 0", exp_q.size()); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/branch_resolve.md
BRANCH_RESOLVE -- requirements
Module: branch_resolve

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16, meaning PC/target width in bits.
REQ-002 SHALL have parameter OFFSET_WIDTH, default 8, meaning signed branch offset width.
REQ-003 SHALL have parameter FLUSH_CYCLES, default 2, meaning flush pulse length after a taken branch; legal range 1..15.
REQ-004 SHALL have ports, clock and reset first:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- branch_d  in  1  decode-stage branch request.
- branch_condition_d  in  4  condition code.
- pc_d  in  ADDR_WIDTH  PC of the branch instruction.
- offset_d  in  OFFSET_WIDTH  signed offset.
- flag_we  in  1  latch ALU flags this cycle.
- Z, N, V, C  in  1 each  ALU flags.
- stall  in  1  pipeline stall.
- PC_source  out  1  select branch_target for the next PC.
- branch_target  out  ADDR_WIDTH  resolved target.
- flush  out  1  squash younger instructions.
- busy  out  1  FSM not in IDLE.
- flags_q  out  4  registered {Z,N,V,C}.
REQ-005 SHALL use one clock; reset is synchronous and active-high.

Function
REQ-006 SHALL update flags_q with {Z,N,V,C} on the clock edge when flag_we=1, and hold it otherwise.
REQ-007 SHALL evaluate the condition against the incoming {Z,N,V,C} when flag_we=1 in the same cycle (forwarding), and against flags_q otherwise.
REQ-008 SHALL decode conditions as follows:
- 0 always; 1 Z; 2 !Z; 3 C; 4 !C; 5 N; 6 !N; 7 V; 8 !V.
- 9 C&!Z; A !C|Z; B N==V; C N!=V; D !Z&(N==V); E Z|(N!=V); F never.
REQ-009 SHALL accept a branch only when branch_d=1, stall=0 and the FSM is in IDLE; branch_d in FLUSH SHALL be ignored.
REQ-010 SHALL compute branch_target = pc_d + sign-extended offset_d, modulo 2^ADDR_WIDTH (wrap, no error); register it on acceptance and hold it until the next accepted taken branch.
REQ-011 SHALL handle an accepted taken branch as follows:
- Next cycle: PC_source=1 for exactly one cycle, flush=1, FSM enters FLUSH.
- Latency: one cycle from acceptance to PC_source.
REQ-012 SHALL treat an accepted not-taken branch, including condition F, as producing no PC_source, no flush and no state change.
REQ-013 SHALL run the FSM with states IDLE and FLUSH:
- FLUSH holds flush=1 for FLUSH_CYCLES unstalled cycles, counted by a down-counter, then returns to IDLE.
- stall=1 freezes the counter.
REQ-014 SHALL drive busy=1 exactly while in FLUSH; the cycle the FSM returns to IDLE it SHALL accept a new branch.

Reset
REQ-015 SHALL on reset set the FSM to IDLE, the counter to 0 and flags_q, branch_target, PC_source and flush to 0, overriding any simultaneous flag_we or branch_d.
REQ-016 SHALL, on reset during FLUSH, deassert flush and busy on the next edge and lose the pending flush.

Configuration
REQ-017 SHALL, with BRANCH_STATS_EN defined, add outputs taken_count[15:0] and not_taken_count[15:0]:
- Each increments once per accepted branch of that outcome.
- Each saturates at 16'hFFFF.
- Both reset to 0.
REQ-018 SHALL, without BRANCH_STATS_EN, have neither port nor counters.

Structure
REQ-019 SHALL place the condition-code constants (COND_AL..COND_NV) and the FSM state encoding in shared package branch_pkg.
REQ-020 SHALL implement condition decoding as combinational sub-module branch_cond_eval (inputs: cond[3:0], flags[3:0]; output: taken).

Verification
REQ-021 SHALL verify that flag_we=1 with C=1, then cond=3 at pc_d=16'h0010, offset_d=8'h04 -> next cycle PC_source=1, branch_target=16'h0014, flush high 2 cycles.
REQ-022 SHALL verify that flag_we=1 with {Z,N,V,C}=4'b0000 in the same cycle as branch_d=1, cond=1 -> not taken, no PC_source, flush=0 (forwarding).
REQ-023 SHALL verify that pc_d=16'h0002, offset_d=8'hFC, cond=0 -> branch_target=16'hFFFE (wrap).
REQ-024 SHALL verify that a taken branch followed by branch_d=1 during FLUSH -> second branch ignored, single PC_source pulse.
REQ-025 SHALL verify that stall=1 for 3 cycles mid-FLUSH -> flush lasts FLUSH_CYCLES+3 cycles; reset mid-FLUSH -> flush=0 and busy=0 next edge.
REQ-026 SHALL verify, with BRANCH_STATS_EN, that 3 taken and 2 not-taken branches -> taken_count=3, not_taken_count=2.
